axi4_lite_reg_master: RTL and testbench
=======================================

// Module: axi4_lite_reg_master
// PURPOSE
// - Single-outstanding AXI4-Lite initiator that converts a simple command/response handshake into AXI4-Lite
//   read and write transactions.
// - Used by local controllers and sequencers (e.g. boot-time register init) to program AXI4-Lite register
//   slaves on the control bus.
// - Exactly one transaction is in flight at any time.
// PARAMETERS
// - ADDR_WIDTH            32    AXI address width.
// - AXI_DATA_WIDTH        32    AXI data width; wstrb width is AXI_DATA_WIDTH/8.
// - SAME_CYCLE_ADDR_DATA  1     1: awvalid and wvalid are raised together. 0: wvalid is raised only after the AW handshake.
// - TIMEOUT_CYCLES        1024  Watchdog limit, in cycles. Used only with AXI4_LITE_MASTER_TIMEOUT_EN.
// PORTS
// - clk           in   1                Clock.
// - rst_n         in   1                Synchronous reset, active-low.
// - i_cmd_valid   in   1                Command valid.
// - o_cmd_ready   out  1                Command accepted when i_cmd_valid & o_cmd_ready.
// - i_cmd_write   in   1                1 = write, 0 = read.
// - i_cmd_addr    in   ADDR_WIDTH       Target byte address.
// - i_cmd_wdata   in   AXI_DATA_WIDTH   Write data; ignored for reads.
// - i_cmd_wstrb   in   AXI_DATA_WIDTH/8 Write strobes; ignored for reads.
// - o_rsp_valid   out  1                Response valid.
// - i_rsp_ready   in   1                Response consumed when o_rsp_valid & i_rsp_ready.
// - o_rsp_rdata   out  AXI_DATA_WIDTH   Read data; 0 for writes.
// - o_rsp_resp    out  2                AXI response code (rresp or bresp).
// - if_axi        ifc_axi4_lite.master  AXI4-Lite master port.
// BEHAVIOUR
// - Clock and reset: clk, rst_n (synchronous, active-low).
// - Reset values:
//   - State IDLE; o_cmd_ready = 1.
//   - o_rsp_valid, awvalid, wvalid, arvalid, bready, rready all 0.
//   - o_rsp_rdata, o_rsp_resp, awaddr, wdata, wstrb, araddr all '0.
// - awprot and arprot are tied to 3'b000.
// - FSM states: IDLE, WR_AW_W, WR_W, WR_B, RD_AR, RD_R, RSP.
// - IDLE:
//   - o_cmd_ready = (state == IDLE).
//   - On command accept, capture addr/wdata/wstrb into AXI registers.
//   - Go to WR_AW_W if write, RD_AR if read.
//   - Valid signals rise the cycle after accept (1-cycle registered latency).
// - WR_AW_W:
//   - awvalid = 1; wvalid = 1 if SAME_CYCLE_ADDR_DATA, else 0.
//   - AW and W handshakes are tracked independently; each valid drops the cycle after its own handshake.
//   - Both done in the same cycle -> WR_B.
//   - AW done only -> WR_W (wvalid = 1).
//   - W done only -> stay until AW is done.
// - WR_W: hold wvalid until the W handshake, then go to WR_B.
// - WR_B:
//   - bready = 1.
//   - On the B handshake, latch bresp, set o_rsp_rdata = 0, go to RSP.
// - RD_AR: arvalid = 1 until the AR handshake, then go to RD_R.
// - RD_R:
//   - rready = 1.
//   - On the R handshake, latch rdata and rresp, go to RSP.
// - RSP:
//   - o_rsp_valid = 1, with data held stable.
//   - On the response handshake, go to IDLE. The next command can be accepted the following cycle.
// - AXI compliance:
//   - Once a valid is asserted, it and its payload are held until the handshake.
//   - No valid ever depends combinationally on a ready.
// - Mid-operation reset: all valids drop immediately; the in-flight transaction is discarded and no response is produced.
// - Minimum command-to-response latency:
//   - Read: 3 cycles (zero-wait slave).
//   - Write: 3 cycles with SAME_CYCLE_ADDR_DATA=1; 4 cycles with SAME_CYCLE_ADDR_DATA=0.
// CONFIGURATION
// - Macro AXI4_LITE_MASTER_TIMEOUT_EN.
// - Defined:
//   - A cycle counter runs in every non-IDLE, non-RSP state and is cleared on each AXI handshake.
//   - When the counter reaches TIMEOUT_CYCLES-1, all valids/readies drop, o_rsp_resp = 2'b11 (DECERR),
//     o_rsp_rdata = '0, and the FSM goes to RSP.
//   - This is a deliberate protocol abort for hung-slave recovery.
// - Undefined: no counter; the block waits indefinitely for the slave.
// TESTING
// - Read, zero-wait slave:
//   - Command: read addr 0x10, slave returns rdata 0xDEADBEEF, rresp OKAY.
//   - Expect: arvalid in cycle +1; rsp_valid 3 cycles after accept; rsp_rdata 0xDEADBEEF; rsp_resp 2'b00.
// - Write, SAME_CYCLE_ADDR_DATA=1, slave gives wready 2 cycles after awready:
//   - Command: write 0x04 / 0x12345678 / wstrb 0xF.
//   - Expect: awvalid drops after the AW handshake; wvalid holds until wready; rsp_resp = bresp.
// - Write, SAME_CYCLE_ADDR_DATA=0:
//   - Expect: wvalid 0 until the AW handshake completes; wdata 0x12345678 is stable while wvalid = 1.
// - Response backpressure:
//   - Hold i_rsp_ready = 0 for 5 cycles.
//   - Expect: rsp fields stable; o_cmd_ready = 0; no new AXI valids.
// - SLVERR:
//   - Slave answers the read with rresp 2'b10.
//   - Expect: rsp_resp 2'b10; the next command is accepted 1 cycle after the response handshake.
// - Timeout (macro defined), TIMEOUT_CYCLES = 16, arready never asserted:
//   - Expect: arvalid drops after 16 cycles; rsp_resp 2'b11.
//   - With the macro undefined: no response for 100 cycles.

Source files
------------

// File: rtl/axi4_lite_reg_master_if.sv
// AXI4-Lite bus bundle shared by the register master and its slaves.
interface ifc_axi4_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_lite_reg_master.sv
// Single-outstanding AXI4-Lite initiator behind a cmd/rsp handshake.
// Optional hung-slave watchdog: AXI4_LITE_MASTER_TIMEOUT_EN.
module axi4_lite_reg_master #(
  parameter int ADDR_WIDTH           = 32,
  parameter int AXI_DATA_WIDTH       = 32,
  parameter bit SAME_CYCLE_ADDR_DATA = 1'b1,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]       i_cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                  o_rsp_resp,
  ifc_axi4_lite.master                if_axi
);
  localparam int SW = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, WR_AW_W, WR_W, WR_B, RD_AR, RD_R, RSP
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]             wstrb_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                resp_q;
  logic                      w_done_q, w_done_nx;

  logic aw_v, w_v, ar_v, b_r, r_r;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic any_hs, accept, rsp_hs, busy, tmo;

  assign aw_hs  = aw_v & if_axi.awready;
  assign w_hs   = w_v & if_axi.wready;
  assign b_hs   = b_r & if_axi.bvalid;
  assign ar_hs  = ar_v & if_axi.arready;
  assign r_hs   = r_r & if_axi.rvalid;
  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign busy   = (state != IDLE) && (state != RSP);

  assign o_cmd_ready = (state == IDLE);
  assign accept      = i_cmd_valid & o_cmd_ready;
  assign o_rsp_valid = (state == RSP) & rst_n;
  assign rsp_hs      = o_rsp_valid & i_rsp_ready;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_resp  = resp_q;

  // Valids come from registered state only; rst_n kills them at once.
  assign if_axi.awvalid = aw_v & rst_n;
  assign if_axi.wvalid  = w_v & rst_n;
  assign if_axi.arvalid = ar_v & rst_n;
  assign if_axi.bready  = b_r & rst_n;
  assign if_axi.rready  = r_r & rst_n;
  assign if_axi.awaddr  = addr_q;
  assign if_axi.araddr  = addr_q;
  assign if_axi.wdata   = wdata_q;
  assign if_axi.wstrb   = wstrb_q;
  assign if_axi.awprot  = 3'b000;
  assign if_axi.arprot  = 3'b000;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!busy || any_hs) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A handshake landing on the limit cycle wins over the abort.
  assign tmo = busy && !any_hs &&
               (cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo        = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    w_done_nx = w_done_q;
    aw_v      = 1'b0;
    w_v       = 1'b0;
    ar_v      = 1'b0;
    b_r       = 1'b0;
    r_r       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx  = i_cmd_write ? WR_AW_W : RD_AR;
          w_done_nx = 1'b0;
        end
      end
      WR_AW_W: begin
        aw_v = 1'b1;
        w_v  = SAME_CYCLE_ADDR_DATA && !w_done_q;
        if (w_hs) w_done_nx = 1'b1;
        if (aw_hs) begin
          state_nx = (w_hs || w_done_q) ? WR_B : WR_W;
        end
      end
      WR_W: begin
        w_v = 1'b1;
        if (w_hs) state_nx = WR_B;
      end
      WR_B: begin
        b_r = 1'b1;
        if (b_hs) state_nx = RSP;
      end
      RD_AR: begin
        ar_v = 1'b1;
        if (ar_hs) state_nx = RD_R;
      end
      RD_R: begin
        r_r = 1'b1;
        if (r_hs) state_nx = RSP;
      end
      RSP: begin
        if (rsp_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (tmo) state_nx = RSP;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      w_done_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      resp_q   <= '0;
    end else begin
      state    <= state_nx;
      w_done_q <= w_done_nx;
      if (accept) begin
        addr_q  <= i_cmd_addr;
        wdata_q <= i_cmd_wdata;
        wstrb_q <= i_cmd_wstrb;
      end
      if (b_hs) begin
        rdata_q <= '0;
        resp_q  <= if_axi.bresp;
      end
      if (r_hs) begin
        rdata_q <= if_axi.rdata;
        resp_q  <= if_axi.rresp;
      end
      if (tmo) begin
        rdata_q <= '0;
        resp_q  <= 2'b11;
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_reg_master.sv
// Directed bench for axi4_lite_reg_master: u0 same-cycle AW/W, u1 split.
// Timeout scenario runs only when AXI4_LITE_MASTER_TIMEOUT_EN is defined.
module tb_axi4_lite_reg_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic        c_valid, c_write, c_ready, r_valid, r_ready;
  logic [31:0] c_addr, c_wdata, r_rdata;
  logic [3:0]  c_wstrb;
  logic [1:0]  r_resp;

  logic        c_valid1, c_write1, c_ready1, r_valid1, r_ready1;
  logic [31:0] c_addr1, c_wdata1, r_rdata1;
  logic [3:0]  c_wstrb1;
  logic [1:0]  r_resp1;

  ifc_axi4_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ax0 ();
  ifc_axi4_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ax1 ();

  axi4_lite_reg_master #(
    .SAME_CYCLE_ADDR_DATA(1'b1), .TIMEOUT_CYCLES(TMO)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(c_valid), .o_cmd_ready(c_ready),
    .i_cmd_write(c_write), .i_cmd_addr(c_addr),
    .i_cmd_wdata(c_wdata), .i_cmd_wstrb(c_wstrb),
    .o_rsp_valid(r_valid), .i_rsp_ready(r_ready),
    .o_rsp_rdata(r_rdata), .o_rsp_resp(r_resp),
    .if_axi(ax0.master)
  );

  axi4_lite_reg_master #(
    .SAME_CYCLE_ADDR_DATA(1'b0), .TIMEOUT_CYCLES(TMO)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(c_valid1), .o_cmd_ready(c_ready1),
    .i_cmd_write(c_write1), .i_cmd_addr(c_addr1),
    .i_cmd_wdata(c_wdata1), .i_cmd_wstrb(c_wstrb1),
    .o_rsp_valid(r_valid1), .i_rsp_ready(r_ready1),
    .o_rsp_rdata(r_rdata1), .o_rsp_resp(r_resp1),
    .if_axi(ax1.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    c_valid = 0; c_write = 0; c_addr = 0; c_wdata = 0;
    c_wstrb = 0; r_ready = 0;
    c_valid1 = 0; c_write1 = 0; c_addr1 = 0; c_wdata1 = 0;
    c_wstrb1 = 0; r_ready1 = 0;
    ax0.awready = 0; ax0.wready = 0; ax0.bvalid = 0; ax0.bresp = 0;
    ax0.arready = 0; ax0.rvalid = 0; ax0.rdata = 0; ax0.rresp = 0;
    ax1.awready = 0; ax1.wready = 0; ax1.bvalid = 0; ax1.bresp = 0;
    ax1.arready = 0; ax1.rvalid = 0; ax1.rdata = 0; ax1.rresp = 0;
  endtask

  task automatic send0(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    c_valid = 1; c_write = w; c_addr = a; c_wdata = d; c_wstrb = s;
    n_chk++;
    if (c_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_ready_before_accept: got %b want 1", c_ready);
    end
    tick();
    c_valid = 0;
  endtask

  task automatic rsp_done0();
    r_ready = 1;
    tick();
    r_ready = 0;
    n_chk++;
    if ({r_valid, c_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rsp_done: got valid/ready %b want 01",
               {r_valid, c_ready});
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick();
    tick();
    n_chk++;
    if ({c_ready, r_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b want 10", {c_ready, r_valid});
    end
    n_chk++;
    if ({ax0.awvalid, ax0.wvalid, ax0.arvalid, ax0.bready, ax0.rready}
        !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_axi_valids: got %b want 00000",
               {ax0.awvalid, ax0.wvalid, ax0.arvalid,
                ax0.bready, ax0.rready});
    end
    n_chk++;
    if ({r_rdata, r_resp, ax0.awaddr, ax0.araddr, ax0.wdata, ax0.wstrb,
         ax0.awprot, ax0.arprot} !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: rdata %h resp %b awaddr %h wdata %h",
               r_rdata, r_resp, ax0.awaddr, ax0.wdata);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_read();
    send0(1'b0, 32'h10, 32'h0, 4'h0);
    n_chk++;
    if ({ax0.arvalid, ax0.araddr, r_valid} !== {1'b1, 32'h10, 1'b0}) begin
      n_fail++;
      $display("FAIL read_ar: got arvalid %b araddr %h want 1 00000010",
               ax0.arvalid, ax0.araddr);
    end
    ax0.arready = 1;
    tick();
    ax0.arready = 0;
    n_chk++;
    if ({ax0.arvalid, ax0.rready} !== 2'b01) begin
      n_fail++;
      $display("FAIL read_r_phase: got %b want 01",
               {ax0.arvalid, ax0.rready});
    end
    ax0.rvalid = 1; ax0.rdata = 32'hDEADBEEF; ax0.rresp = 2'b00;
    tick();
    ax0.rvalid = 0;
    n_chk++;
    if ({r_valid, r_rdata, r_resp} !== {1'b1, 32'hDEADBEEF, 2'b00}) begin
      n_fail++;
      $display("FAIL read_rsp: got %b %h %b want 1 deadbeef 00",
               r_valid, r_rdata, r_resp);
    end
    rsp_done0();
  endtask

  task automatic test_write_same();
    send0(1'b1, 32'h04, 32'h12345678, 4'hF);
    n_chk++;
    if ({ax0.awvalid, ax0.wvalid, ax0.awaddr, ax0.wdata, ax0.wstrb}
        !== {2'b11, 32'h04, 32'h12345678, 4'hF}) begin
      n_fail++;
      $display("FAIL wr_same_start: got %b %h %h %h",
               {ax0.awvalid, ax0.wvalid}, ax0.awaddr, ax0.wdata, ax0.wstrb);
    end
    ax0.awready = 1;
    tick();
    ax0.awready = 0;
    n_chk++;
    if ({ax0.awvalid, ax0.wvalid} !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_same_aw_drop: got %b want 01",
               {ax0.awvalid, ax0.wvalid});
    end
    tick();
    n_chk++;
    if ({ax0.wvalid, ax0.wdata, ax0.bready} !== {1'b1, 32'h12345678, 1'b0})
    begin
      n_fail++;
      $display("FAIL wr_same_w_hold: got %b %h %b want 1 12345678 0",
               ax0.wvalid, ax0.wdata, ax0.bready);
    end
    ax0.wready = 1;
    tick();
    ax0.wready = 0;
    n_chk++;
    if ({ax0.wvalid, ax0.bready} !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_same_b_phase: got %b want 01",
               {ax0.wvalid, ax0.bready});
    end
    ax0.bvalid = 1; ax0.bresp = 2'b01;
    tick();
    ax0.bvalid = 0;
    n_chk++;
    if ({r_valid, r_rdata, r_resp} !== {1'b1, 32'h0, 2'b01}) begin
      n_fail++;
      $display("FAIL wr_same_rsp: got %b %h %b want 1 00000000 01",
               r_valid, r_rdata, r_resp);
    end
    rsp_done0();
  endtask

  task automatic test_w_first();
    send0(1'b1, 32'h08, 32'hCAFEF00D, 4'h3);
    ax0.wready = 1;
    tick();
    ax0.wready = 0;
    n_chk++;
    if ({ax0.awvalid, ax0.wvalid, ax0.bready} !== 3'b100) begin
      n_fail++;
      $display("FAIL w_first_wait_aw: got %b want 100",
               {ax0.awvalid, ax0.wvalid, ax0.bready});
    end
    ax0.awready = 1;
    tick();
    ax0.awready = 0;
    n_chk++;
    if ({ax0.awvalid, ax0.wvalid, ax0.bready} !== 3'b001) begin
      n_fail++;
      $display("FAIL w_first_b_phase: got %b want 001",
               {ax0.awvalid, ax0.wvalid, ax0.bready});
    end
    ax0.bvalid = 1; ax0.bresp = 2'b00;
    tick();
    ax0.bvalid = 0;
    n_chk++;
    if ({r_valid, r_resp} !== 3'b100) begin
      n_fail++;
      $display("FAIL w_first_rsp: got %b %b want 1 00", r_valid, r_resp);
    end
    rsp_done0();
  endtask

  task automatic test_write_split();
    c_valid1 = 1; c_write1 = 1; c_addr1 = 32'h04;
    c_wdata1 = 32'h12345678; c_wstrb1 = 4'hF;
    tick();
    c_valid1 = 0;
    n_chk++;
    if ({ax1.awvalid, ax1.wvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL split_aw_only: got %b want 10",
               {ax1.awvalid, ax1.wvalid});
    end
    tick();
    n_chk++;
    if ({ax1.awvalid, ax1.wvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL split_aw_wait: got %b want 10",
               {ax1.awvalid, ax1.wvalid});
    end
    ax1.awready = 1;
    tick();
    ax1.awready = 0;
    n_chk++;
    if ({ax1.awvalid, ax1.wvalid, ax1.wdata} !== {2'b01, 32'h12345678})
    begin
      n_fail++;
      $display("FAIL split_w_phase: got %b %h want 01 12345678",
               {ax1.awvalid, ax1.wvalid}, ax1.wdata);
    end
    tick();
    n_chk++;
    if ({ax1.wvalid, ax1.wdata, ax1.wstrb} !== {1'b1, 32'h12345678, 4'hF})
    begin
      n_fail++;
      $display("FAIL split_w_stable: got %b %h %h",
               ax1.wvalid, ax1.wdata, ax1.wstrb);
    end
    ax1.wready = 1;
    tick();
    ax1.wready = 0;
    ax1.bvalid = 1; ax1.bresp = 2'b10;
    n_chk++;
    if ({ax1.wvalid, ax1.bready} !== 2'b01) begin
      n_fail++;
      $display("FAIL split_b_phase: got %b want 01",
               {ax1.wvalid, ax1.bready});
    end
    tick();
    ax1.bvalid = 0;
    n_chk++;
    if ({r_valid1, r_rdata1, r_resp1} !== {1'b1, 32'h0, 2'b10}) begin
      n_fail++;
      $display("FAIL split_rsp: got %b %h %b want 1 00000000 10",
               r_valid1, r_rdata1, r_resp1);
    end
    r_ready1 = 1;
    tick();
    r_ready1 = 0;
    n_chk++;
    if ({r_valid1, c_ready1} !== 2'b01) begin
      n_fail++;
      $display("FAIL split_rsp_done: got %b want 01", {r_valid1, c_ready1});
    end
  endtask

  task automatic test_backpressure();
    send0(1'b0, 32'h20, 32'h0, 4'h0);
    ax0.arready = 1;
    tick();
    ax0.arready = 0;
    ax0.rvalid = 1; ax0.rdata = 32'hA5A50001; ax0.rresp = 2'b00;
    tick();
    ax0.rvalid = 0;
    c_valid = 1; c_write = 1; c_addr = 32'h44;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if ({r_valid, r_rdata, r_resp, c_ready, ax0.awvalid, ax0.wvalid,
           ax0.arvalid} !== {1'b1, 32'hA5A50001, 2'b00, 4'b0000}) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got %b %h %b rdy %b av %b",
                 i, r_valid, r_rdata, r_resp, c_ready,
                 {ax0.awvalid, ax0.wvalid, ax0.arvalid});
      end
    end
    c_valid = 0; c_write = 0;
    rsp_done0();
  endtask

  task automatic test_slverr();
    send0(1'b0, 32'h30, 32'h0, 4'h0);
    ax0.arready = 1;
    tick();
    ax0.arready = 0;
    ax0.rvalid = 1; ax0.rdata = 32'h0BAD0BAD; ax0.rresp = 2'b10;
    tick();
    ax0.rvalid = 0;
    n_chk++;
    if ({r_valid, r_rdata, r_resp} !== {1'b1, 32'h0BAD0BAD, 2'b10}) begin
      n_fail++;
      $display("FAIL slverr_rsp: got %b %h %b want 1 0bad0bad 10",
               r_valid, r_rdata, r_resp);
    end
    r_ready = 1;
    tick();
    r_ready = 0;
    send0(1'b0, 32'h34, 32'h0, 4'h0);
    n_chk++;
    if ({ax0.arvalid, ax0.araddr} !== {1'b1, 32'h34}) begin
      n_fail++;
      $display("FAIL slverr_next_cmd: got %b %h want 1 00000034",
               ax0.arvalid, ax0.araddr);
    end
    ax0.arready = 1;
    tick();
    ax0.arready = 0;
    ax0.rvalid = 1; ax0.rdata = 32'h1; ax0.rresp = 2'b00;
    tick();
    ax0.rvalid = 0;
    rsp_done0();
  endtask

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    send0(1'b0, 32'h50, 32'h0, 4'h0);
    for (int i = 0; i < 15; i++) tick();
    n_chk++;
    if ({ax0.arvalid, r_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_before: got %b want 10",
               {ax0.arvalid, r_valid});
    end
    tick();
    n_chk++;
    if ({ax0.arvalid, r_valid, r_rdata, r_resp}
        !== {2'b01, 32'h0, 2'b11}) begin
      n_fail++;
      $display("FAIL timeout_rsp: got %b %h %b want 01 00000000 11",
               {ax0.arvalid, r_valid}, r_rdata, r_resp);
    end
    rsp_done0();
  endtask
`else
  task automatic test_no_timeout();
    logic seen;
    seen = 1'b0;
    send0(1'b0, 32'h50, 32'h0, 4'h0);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (r_valid !== 1'b0 || ax0.arvalid !== 1'b1) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout_wait: got early change %b want 0", seen);
    end
    rst_n = 0;
    #1;
    n_chk++;
    if (ax0.arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset_drop: got arvalid %b want 0", ax0.arvalid);
    end
    tick();
    rst_n = 1;
    tick();
    tick();
    n_chk++;
    if ({c_ready, r_valid, ax0.arvalid} !== 3'b100) begin
      n_fail++;
      $display("FAIL midop_reset_idle: got %b want 100",
               {c_ready, r_valid, ax0.arvalid});
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    init_inputs();
    test_reset();
    test_read();
    test_write_same();
    test_w_first();
    test_write_split();
    test_backpressure();
    test_slverr();
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
